fetch_unit: RTL

- Instruction-fetch stage directly upstream of the control decoder.
- Holds the program counter (PC) and a run/halt state machine.
- Drives the instruction ROM address.
- Applies the decoder's next-cycle control (Ack, GotoEn, Jump2En with the ALU Zero flag, BranchEn, Jump) through a small programmable branch-target table.

---
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage feeding the control decoder. Holds
//                the program counter and an IDLE/RUN/DONE state machine,
//                drives the instruction ROM address, and applies the
//                decoder's next-cycle control (Ack, GotoEn, Jump2En+Zero,
//                BranchEn, Jump) through a small programmable branch-target
//                table of absolute targets and signed relative offsets.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PC_W        PC / ROM address width
//    TBL_DEPTH   number of branch-target entries
//    START_ADDR  PC value loaded on Start
//  Ports
//    Clk         in   system clock, rising edge
//    Reset       in   asynchronous active-low reset
//    Start       in   pulse: enter RUN at START_ADDR (from IDLE or DONE)
//    Stall       in   hold PC and ignore all control this cycle (RUN only)
//    Ack         in   program finished -> DONE, PC frozen
//    GotoEn      in   absolute jump to Abs[TargIdx]
//    Jump2En     in   relative branch by Rel[TargIdx] when Zero is set
//    Zero        in   ALU zero flag
//    BranchEn    in   unconditional relative branch by Rel[TargIdx]
//    Jump        in   skip next instruction (PC+2)
//    TargIdx     in   branch-table read index
//    TblWrEn     in   branch-table write strobe
//    TblWrIdx    in   branch-table write index
//    TblWrAbs    in   absolute target written to the table
//    TblWrRel    in   two's-complement offset written to the table
//    CycleCnt    out  RUN cycle count (only with FETCH_CYCLE_CTR_EN)
//    ProgCtr     out  current PC, registered, ROM address
//    Running     out  high in RUN
//    Done        out  high in DONE
//  Build option
//    FETCH_CYCLE_CTR_EN  adds the saturating 16-bit CycleCnt output
// ============================================================================
module fetch_unit #(
    parameter int              PC_W       = 10,
    parameter int              TBL_DEPTH  = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic                          Stall,
    input  logic                          Ack,
    input  logic                          GotoEn,
    input  logic                          Jump2En,
    input  logic                          Zero,
    input  logic                          BranchEn,
    input  logic                          Jump,
    input  logic [$clog2(TBL_DEPTH)-1:0]  TargIdx,
    input  logic                          TblWrEn,
    input  logic [$clog2(TBL_DEPTH)-1:0]  TblWrIdx,
    input  logic [PC_W-1:0]               TblWrAbs,
    input  logic [PC_W-1:0]               TblWrRel,
`ifdef FETCH_CYCLE_CTR_EN
    output logic [15:0]                   CycleCnt,
`endif
    output logic [PC_W-1:0]               ProgCtr,
    output logic                          Running,
    output logic                          Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_next;
    logic [PC_W-1:0]   abs_tbl [TBL_DEPTH];
    logic [PC_W-1:0]   rel_tbl [TBL_DEPTH];
    logic [PC_W-1:0]   rel_target;

    // Relative offsets are two's complement at full PC width, so a plain
    // modulo-2^PC_W add handles both directions and wrap-around.
    assign rel_target = pc + rel_tbl[TargIdx];

    // ------------------------------------------------------------------
    // State and PC register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            state <= next_state;
            pc    <= pc_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-PC
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        pc_next    = pc;
        case (state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    next_state = S_RUN;
                    pc_next    = START_ADDR;
                end
            end
            S_RUN: begin
                // A stalled cycle swallows every control input, Ack included.
                if (!Stall) begin
                    if (Ack) begin
                        next_state = S_DONE;
                    end else if (GotoEn) begin
                        pc_next = abs_tbl[TargIdx];
                    end else if (Jump2En && Zero) begin
                        pc_next = rel_target;
                    end else if (BranchEn) begin
                        pc_next = rel_target;
                    end else if (Jump) begin
                        pc_next = pc + PC_W'(2);
                    end else begin
                        pc_next = pc + PC_W'(1);
                    end
                end
            end
            default: begin
                next_state = S_IDLE;
                pc_next    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Branch-target table. Reads are taken from the registered contents,
    // so a write coinciding with a redirect to the same index is seen only
    // from the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                abs_tbl[i] <= '0;
                rel_tbl[i] <= '0;
            end
        end else if (TblWrEn) begin
            abs_tbl[TblWrIdx] <= TblWrAbs;
            rel_tbl[TblWrIdx] <= TblWrRel;
        end
    end

`ifdef FETCH_CYCLE_CTR_EN
    // ------------------------------------------------------------------
    // RUN cycle counter: counts stalled cycles too, saturates, holds in
    // DONE and restarts from zero on the Start that enters RUN.
    // ------------------------------------------------------------------
    logic [15:0] cycle_cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cycle_cnt <= '0;
        end else if (state == S_RUN) begin
            if (cycle_cnt != 16'hFFFF) begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end
        end else if (Start) begin
            cycle_cnt <= '0;
        end
    end

    assign CycleCnt = cycle_cnt;
`endif

    assign ProgCtr = pc;
    assign Running = (state == S_RUN);
    assign Done    = (state == S_DONE);

endmodule
`default_nettype wire
